// File: rtl/vm1_bus_ctl.sv
// vm1_bus_ctl -- bus cycle controller for a VM1-style CPU.
//
// Detects the start of a CPU bus cycle from a rising SYNC, classifies the
// latched address (interrupt vector, memory, I/O page or nonexistent), then
// times the reply: a fixed wait for memory, a bounded wait for io_ack_i on
// I/O, a short fixed wait for vector fetches, and a bus-error pulse for
// nonexistent addresses.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-high
//   sync_i     CPU SYNC (address valid)
//   din_i      CPU read strobe
//   dout_i     CPU write strobe
//   wtbt_i     byte transfer qualifier
//   iako_i     interrupt acknowledge
//   addr_i     CPU byte address
//   io_ack_i   I/O device completion
//   rply_o     RPLY to CPU
//   error_o    bus-error pulse (2 cycles)
//   mem_sel_o  memory cycle active
//   io_sel_o   I/O cycle active
//   mem_we_o   one-cycle memory write strobe
//   mem_be_o   memory byte enables
//   vec_oe_o   drive vec_o onto the data bus
//   vec_o      interrupt vector (constant VECTOR)
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | no cycle; waiting for a SYNC rising edge
// S_ADDR  | address latched and decoded; waiting for DIN/DOUT
// S_WAIT  | strobe seen; counting wait cycles / timeout
// S_REPLY | RPLY asserted until both strobes drop
// S_ERROR | bus error pulse, two cycles
// S_HOLD  | cycle finished; waiting for SYNC to drop

module vm1_bus_ctl #(
  parameter int unsigned MEM_WAIT   = 2,
  parameter int unsigned IO_TIMEOUT = 15,
  parameter logic [15:0] IO_BASE    = 16'o177560,
  parameter logic [15:0] VECTOR     = 16'o000064
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sync_i,
  input  logic        din_i,
  input  logic        dout_i,
  input  logic        wtbt_i,
  input  logic        iako_i,
  input  logic [15:0] addr_i,
  input  logic        io_ack_i,
  output logic        rply_o,
  output logic        error_o,
  output logic        mem_sel_o,
  output logic        io_sel_o,
  output logic        mem_we_o,
  output logic [1:0]  mem_be_o,
  output logic        vec_oe_o,
  output logic [15:0] vec_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WAIT, S_REPLY, S_ERROR, S_HOLD
  } state_t;

  typedef enum logic [1:0] {
    C_MEM, C_IO, C_VEC, C_NXM
  } cls_t;

  localparam logic [4:0]  MEM_WAIT_L   = 5'(MEM_WAIT);
  localparam logic [4:0]  IO_TIMEOUT_L = 5'(IO_TIMEOUT);
  localparam logic [15:0] IO_PAGE      = 16'o160000;

  function automatic cls_t decode(input logic [15:0] a, input logic ia);
    if (ia)                return C_VEC;
    else if (a < IO_PAGE)  return C_MEM;
    else if (a >= IO_BASE) return C_IO;
    else                   return C_NXM;
  endfunction

  state_t      state, state_nx;
  logic [4:0]  cnt, cnt_nx;
  logic        sync_q;
  logic        sync_vld;
  logic [15:0] addr_q;
  logic        iako_q;
  logic        wtbt_q;
  logic        we_q;
  logic        mem_we_q;
  logic        sync_rise;
  logic        start_reply;
  logic        strobe;
  cls_t        cls;
  cls_t        cls_ld;
  logic [1:0]  be;

  // sync_vld keeps a SYNC that is already high when reset releases from
  // looking like a rising edge: only a genuinely sampled 0 counts.
  assign sync_rise = sync_vld & ~sync_q & sync_i;
  assign strobe    = din_i | dout_i;
  assign cls       = decode(addr_q, iako_q);
  // IAKO may arrive together with the strobe, so the load decision sees it.
  assign cls_ld    = decode(addr_q, iako_q | iako_i);

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    start_reply = 1'b0;
    case (state)
      S_IDLE: begin
        if (sync_rise) state_nx = S_ADDR;
      end
      S_ADDR: begin
        if (!sync_i) begin
          state_nx = S_IDLE;
        end else if (strobe) begin
          state_nx = S_WAIT;
          case (cls_ld)
            C_MEM:   cnt_nx = MEM_WAIT_L;
            C_IO:    cnt_nx = IO_TIMEOUT_L;
            C_VEC:   cnt_nx = 5'd1;
            default: cnt_nx = 5'd0;
          endcase
        end
      end
      S_WAIT: begin
        if (!sync_i) begin
          state_nx = S_IDLE;
        end else begin
          case (cls)
            C_IO: begin
              // Ack is checked first so it wins over a coinciding expiry;
              // the error fires on the cycle the count reaches zero.
              if (io_ack_i) begin
                state_nx    = S_REPLY;
                start_reply = 1'b1;
              end else if (cnt <= 5'd1) begin
                state_nx = S_ERROR;
                cnt_nx   = 5'd1;
              end else begin
                cnt_nx = cnt - 5'd1;
              end
            end
            C_NXM: begin
              state_nx = S_ERROR;
              cnt_nx   = 5'd1;
            end
            default: begin
              if (cnt == 5'd0) begin
                state_nx    = S_REPLY;
                start_reply = 1'b1;
              end else begin
                cnt_nx = cnt - 5'd1;
              end
            end
          endcase
        end
      end
      S_REPLY: begin
        if (!sync_i)                  state_nx = S_IDLE;
        else if (!din_i && !dout_i)   state_nx = S_HOLD;
      end
      S_ERROR: begin
        if (cnt == 5'd0) state_nx = S_HOLD;
        else             cnt_nx   = cnt - 5'd1;
      end
      S_HOLD: begin
        if (!sync_i) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= 5'd0;
      sync_q   <= 1'b0;
      sync_vld <= 1'b0;
      addr_q   <= 16'd0;
      iako_q   <= 1'b0;
      wtbt_q   <= 1'b0;
      we_q     <= 1'b0;
      mem_we_q <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      sync_q   <= sync_i;
      sync_vld <= 1'b1;
      mem_we_q <= start_reply & (cls == C_MEM) & we_q;
      if (state == S_IDLE && sync_rise) begin
        addr_q <= addr_i;
        iako_q <= iako_i;
        wtbt_q <= wtbt_i;
        we_q   <= 1'b0;
      end
      if (state == S_ADDR) begin
        iako_q <= iako_q | iako_i;
        wtbt_q <= wtbt_q | wtbt_i;
        // DIN and DOUT together count as a write.
        if (strobe) we_q <= dout_i;
      end
    end
  end

  always_comb begin
    be = 2'b11;
    if (wtbt_q) be = addr_q[0] ? 2'b10 : 2'b01;
  end

  assign rply_o    = (state == S_REPLY);
  assign error_o   = (state == S_ERROR);
  assign mem_sel_o = (cls == C_MEM) &&
                     (state == S_ADDR || state == S_WAIT || state == S_REPLY);
  assign io_sel_o  = (cls == C_IO) &&
                     (state == S_ADDR || state == S_WAIT || state == S_REPLY);
  assign vec_oe_o  = (cls == C_VEC) && (state == S_WAIT || state == S_REPLY);
  assign mem_we_o  = mem_we_q;
  assign mem_be_o  = mem_sel_o ? be : 2'b00;
  assign vec_o     = VECTOR;

endmodule
